// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// 8N1 frame constants and the bit-period calculation.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clock cycles per serial bit (integer division; callers keep it >= 2).
    function automatic int calc_bit_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Small single-clock byte FIFO with full/empty/count. The head entry is read
// combinationally so the transmitter can load its shift register on the pop edge.
module uart_tx_buffered_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;

    // Storage array: data needs no reset, only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count moves by at most one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes are queued in a small FIFO and shifted
// out LSB first on SOut. Consecutive frames run back to back with no idle gap.
// TxIRQ is a level request raised while nothing is queued or being sent.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          DataInValid,
    input  logic [7:0]                    DataIn,
    output logic                          DataInReady,
    output logic                          SOut,
    output logic                          TxIRQ,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int BAUD_W     = $clog2(BIT_CYCLES);
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              sout_q, sout_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              baud_end;

    // Ready comes from the registered count only; a pop on this edge does not
    // open a slot until the next cycle.
    assign DataInReady = ~fifo_full;
    assign fifo_push   = DataInValid & DataInReady;
    assign FifoCount   = fifo_count;
    assign SOut        = sout_q;
    assign TxIRQ       = fifo_empty & (state_q == ST_IDLE);
    assign baud_end    = (baud_q == BAUD_LAST);

    uart_tx_buffered_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .push_i    (fifo_push),
        .wr_data_i (DataIn),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Next-state logic: frame sequencing, baud timing, bit shifting, FIFO pops.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    idx_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        idx_d    = '0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so SOut is a clean register output.
    always_comb begin
        sout_d = LINE_IDLE;
        case (state_d)
            ST_START: sout_d = START_BIT;
            ST_DATA:  sout_d = shift_d[0];
            ST_STOP:  sout_d = STOP_BIT;
            default:  sout_d = LINE_IDLE;
        endcase
    end

    // State registers; reset abandons any frame and drives the line high at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sout_q  <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sout_q  <= sout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with BIT_CYCLES = 10: idle state, single
// frame timing, back-to-back frames, overflow drop, async reset mid-frame and
// refilling a full FIFO as the transmitter frees a slot.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       ready;
    logic       sout;
    logic       irq;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic seen_low;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (8)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .DataInValid (valid),
        .DataIn      (din),
        .DataInReady (ready),
        .SOut        (sout),
        .TxIRQ       (irq),
        .FifoCount   (count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance on negedges until the line goes low; a missing start bit fails the check.
    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        while (sout !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_start_seen"}, 32'(sout), 32'(0));
    endtask

    // Called at the first cycle of a start bit; checks all 100 cycles of the frame
    // and returns at the cycle right after the stop bit.
    task automatic frame_check(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        logic [9:0] obs;
        logic [9:0] want;
        logic       irq_seen;
        bits     = {1'b1, b, 1'b0};
        irq_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
                obs[c]   = sout;
                irq_seen = irq_seen | irq;
                @(negedge clk);
            end
            want = {10{bits[k]}};
            check_val($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'(want));
        end
        check_val({tag, "_irq_low"}, 32'(irq_seen), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_val("t1_idle", 32'({sout, irq, ready, count}), 32'(7'b1110000));
        end

        // 2: single 0xA5 frame, exact latency
        valid = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        check_val("t2_sout_before_pop", 32'(sout), 32'(1));
        check_val("t2_count", 32'(count), 32'(1));
        check_val("t2_irq", 32'(irq), 32'(0));
        @(negedge clk);
        frame_check("t2", 8'hA5);
        check_val("t2_after", 32'({sout, irq, count}), 32'(6'b110000));

        // 3: three back-to-back frames
        fork
            begin
                valid = 1'b1;
                din   = 8'h00;
                @(negedge clk);
                din = 8'hFF;
                @(negedge clk);
                din = 8'h3C;
                @(negedge clk);
                valid = 1'b0;
            end
            begin
                wait_start("t3", 50);
                frame_check("t3a", 8'h00);
                frame_check("t3b", 8'hFF);
                frame_check("t3c", 8'h3C);
            end
        join
        check_val("t3_after", 32'({sout, irq, count}), 32'(6'b110000));

        // 4: ten bytes with Valid held; the tenth is dropped
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    valid = 1'b1;
                    din   = 8'(8'h10 + i);
                    @(negedge clk);
                    if (i == 1) check_val("t4_push_pop_count", 32'(count), 32'(1));
                    if (i == 8) check_val("t4_full", 32'({ready, count}), 32'(5'b01000));
                    if (i == 9) check_val("t4_drop", 32'({ready, count}), 32'(5'b01000));
                end
                valid = 1'b0;
            end
            begin
                wait_start("t4", 50);
                for (int j = 0; j < 9; j++) begin
                    frame_check($sformatf("t4_f%0d", j), 8'(8'h10 + j));
                end
            end
        join
        seen_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sout !== 1'b1) seen_low = 1'b1;
            @(negedge clk);
        end
        check_val("t4_no_extra_frame", 32'(seen_low), 32'(0));
        check_val("t4_empty", 32'({irq, count}), 32'(5'b10000));

        // 5: asynchronous reset in the middle of a data bit
        fork
            begin
                valid = 1'b1;
                din   = 8'h55;
                @(negedge clk);
                din = 8'h66;
                @(negedge clk);
                din = 8'h77;
                @(negedge clk);
                valid = 1'b0;
            end
            begin
                wait_start("t5", 50);
                repeat (25) @(negedge clk);
            end
        join
        check_val("t5_pre_reset_bit", 32'(sout), 32'(0));
        #2 rst = 1'b1;
        #1 check_val("t5_async", 32'({sout, irq, ready, count}), 32'(7'b1110000));
        @(negedge clk);
        rst = 1'b0;
        seen_low = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (sout !== 1'b1) seen_low = 1'b1;
            @(negedge clk);
        end
        check_val("t5_no_frame_after", 32'(seen_low), 32'(0));
        check_val("t5_cleared", 32'({irq, count}), 32'(5'b10000));
        valid = 1'b1;
        din   = 8'h81;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        frame_check("t5_81", 8'h81);

        // 6: fill the FIFO, then a held byte enters once a pop frees a slot
        fork
            begin
                int n;
                for (int i = 0; i < 9; i++) begin
                    valid = 1'b1;
                    din   = 8'(8'h20 + i);
                    @(negedge clk);
                end
                check_val("t6_full", 32'({ready, count}), 32'(5'b01000));
                din = 8'h29;
                n   = 0;
                while (ready !== 1'b1 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check_val("t6_slot_freed", 32'(count), 32'(7));
                @(negedge clk);
                valid = 1'b0;
                check_val("t6_refilled", 32'(count), 32'(8));
            end
            begin
                wait_start("t6", 50);
                for (int j = 0; j < 10; j++) begin
                    frame_check($sformatf("t6_f%0d", j), 8'(8'h20 + j));
                end
            end
        join
        check_val("t6_after", 32'({sout, irq, count}), 32'(6'b110000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
